// File: rtl/unidade_controle_sequencia.sv
// Moore sequencer for the memory-game datapath: drives counter/register strobes and reports the outcome.
// Optional feature: define UC_TIMEOUT_EN to enable the player timeout (conta_timer and fim_timer).
module unidade_controle_sequencia (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada_feita,
  input  logic       igual,
  input  logic       fim_sequencia,
  input  logic       ultima_sequencia,
  input  logic       fim_timer,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraL,
  output logic       contaL,
  output logic       zeraR,
  output logic       registraR,
  output logic       zera_timer,
  output logic       conta_timer,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    INICIO_RODADA  = 4'h2,
    ESPERA_JOGADA  = 4'h3,
    REGISTRA       = 4'h4,
    COMPARACAO     = 4'h5,
    PROXIMO        = 4'h6,
    PROXIMA_RODADA = 4'h7,
    FIM_ACERTOU    = 4'hA,
    FIM_TIMEOUT    = 4'hD,
    FIM_ERROU      = 4'hE
  } estado_t;

`ifdef UC_TIMEOUT_EN
  localparam logic TIMEOUT_EN = 1'b1;
`else
  localparam logic TIMEOUT_EN = 1'b0;
`endif

  estado_t estado;

  function automatic estado_t proximo_estado(
    input estado_t atual,
    input logic    ini,
    input logic    jogada,
    input logic    ig,
    input logic    fim_seq,
    input logic    ultima,
    input logic    fim_tmr
  );
    estado_t prox;
    prox = INICIAL;
    case (atual)
      INICIAL:        prox = ini ? PREPARACAO : INICIAL;
      PREPARACAO:     prox = INICIO_RODADA;
      INICIO_RODADA:  prox = ESPERA_JOGADA;
      // A move arriving together with the timeout still counts as a move.
      ESPERA_JOGADA: begin
        if (jogada)                        prox = REGISTRA;
        else if (fim_tmr && TIMEOUT_EN)    prox = FIM_TIMEOUT;
        else                               prox = ESPERA_JOGADA;
      end
      REGISTRA:       prox = COMPARACAO;
      COMPARACAO: begin
        if (!ig)                           prox = FIM_ERROU;
        else if (fim_seq && ultima)        prox = FIM_ACERTOU;
        else if (fim_seq)                  prox = PROXIMA_RODADA;
        else                               prox = PROXIMO;
      end
      PROXIMO:        prox = ESPERA_JOGADA;
      PROXIMA_RODADA: prox = INICIO_RODADA;
      FIM_ACERTOU:    prox = ini ? PREPARACAO : FIM_ACERTOU;
      FIM_ERROU:      prox = ini ? PREPARACAO : FIM_ERROU;
      FIM_TIMEOUT:    prox = ini ? PREPARACAO : FIM_TIMEOUT;
      default:        prox = INICIAL;
    endcase
    return prox;
  endfunction

  // Outputs are registered from the next state, so they always match the state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado      <= INICIAL;
      zeraE       <= 1'b0;
      contaE      <= 1'b0;
      zeraL       <= 1'b0;
      contaL      <= 1'b0;
      zeraR       <= 1'b0;
      registraR   <= 1'b0;
      zera_timer  <= 1'b0;
      conta_timer <= 1'b0;
      pronto      <= 1'b0;
      acertou     <= 1'b0;
      errou       <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      estado      <= proximo_estado(estado, iniciar, jogada_feita, igual,
                                    fim_sequencia, ultima_sequencia, fim_timer);
      zeraE       <= proximo_estado(estado, iniciar, jogada_feita, igual, fim_sequencia,
                                    ultima_sequencia, fim_timer) inside {PREPARACAO, INICIO_RODADA};
      contaE      <= proximo_estado(estado, iniciar, jogada_feita, igual, fim_sequencia,
                                    ultima_sequencia, fim_timer) == PROXIMO;
      zeraL       <= proximo_estado(estado, iniciar, jogada_feita, igual, fim_sequencia,
                                    ultima_sequencia, fim_timer) == PREPARACAO;
      contaL      <= proximo_estado(estado, iniciar, jogada_feita, igual, fim_sequencia,
                                    ultima_sequencia, fim_timer) == PROXIMA_RODADA;
      zeraR       <= proximo_estado(estado, iniciar, jogada_feita, igual, fim_sequencia,
                                    ultima_sequencia, fim_timer) == PREPARACAO;
      registraR   <= proximo_estado(estado, iniciar, jogada_feita, igual, fim_sequencia,
                                    ultima_sequencia, fim_timer) == REGISTRA;
      zera_timer  <= proximo_estado(estado, iniciar, jogada_feita, igual, fim_sequencia,
                                    ultima_sequencia, fim_timer) inside {PREPARACAO, INICIO_RODADA, REGISTRA};
      conta_timer <= TIMEOUT_EN && (proximo_estado(estado, iniciar, jogada_feita, igual, fim_sequencia,
                                    ultima_sequencia, fim_timer) == ESPERA_JOGADA);
      pronto      <= proximo_estado(estado, iniciar, jogada_feita, igual, fim_sequencia,
                                    ultima_sequencia, fim_timer) inside {FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT};
      acertou     <= proximo_estado(estado, iniciar, jogada_feita, igual, fim_sequencia,
                                    ultima_sequencia, fim_timer) == FIM_ACERTOU;
      errou       <= proximo_estado(estado, iniciar, jogada_feita, igual, fim_sequencia,
                                    ultima_sequencia, fim_timer) == FIM_ERROU;
      timeout     <= proximo_estado(estado, iniciar, jogada_feita, igual, fim_sequencia,
                                    ultima_sequencia, fim_timer) == FIM_TIMEOUT;
    end
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_unidade_controle_sequencia.sv
// Directed bench for unidade_controle_sequencia: expected state/outputs queued per step, checked after each edge.
// Honours UC_TIMEOUT_EN the same way as the design.
module tb_unidade_controle_sequencia;

  logic clock = 1'b0;
  logic reset, iniciar, jogada_feita, igual, fim_sequencia, ultima_sequencia, fim_timer;
  logic zeraE, contaE, zeraL, contaL, zeraR, registraR, zera_timer, conta_timer;
  logic pronto, acertou, errou, timeout;
  logic [3:0] db_estado;

  typedef struct {
    string       tag;
    logic [15:0] esperado;
  } item_t;

  item_t fila[$];
  int vetores    = 0;
  int divergencias = 0;

  unidade_controle_sequencia dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
    .igual(igual), .fim_sequencia(fim_sequencia), .ultima_sequencia(ultima_sequencia),
    .fim_timer(fim_timer), .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL),
    .zeraR(zeraR), .registraR(registraR), .zera_timer(zera_timer), .conta_timer(conta_timer),
    .pronto(pronto), .acertou(acertou), .errou(errou), .timeout(timeout), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Reference output table, bit order:
  // zeraE contaE zeraL contaL zeraR registraR zera_timer conta_timer pronto acertou errou timeout
  function automatic logic [11:0] saidas_esperadas(input logic [3:0] s);
    case (s)
      4'h1: return 12'hAA0;
`ifdef UC_TIMEOUT_EN
      4'h3: return 12'h010;
`else
      4'h3: return 12'h000;
`endif
      4'h2: return 12'h820;
      4'h4: return 12'h060;
      4'h6: return 12'h400;
      4'h7: return 12'h100;
      4'hA: return 12'h00C;
      4'hE: return 12'h00A;
      4'hD: return 12'h009;
      default: return 12'h000;
    endcase
  endfunction

  task automatic check_output();
    item_t it;
    logic [15:0] obs;
    it  = fila.pop_front();
    obs = {db_estado, zeraE, contaE, zeraL, contaL, zeraR, registraR, zera_timer,
           conta_timer, pronto, acertou, errou, timeout};
    vetores++;
    assert (obs === it.esperado) else begin
      divergencias++;
      $error("[TB] FAIL %s: observed estado=%h saidas=%h, expected estado=%h saidas=%h",
             it.tag, obs[15:12], obs[11:0], it.esperado[15:12], it.esperado[11:0]);
    end
  endtask

  // Queue the expected state, let one edge pass, then compare.
  task automatic apply_stimulus(input string tag, input logic [3:0] estado_esperado);
    item_t it;
    it.tag      = tag;
    it.esperado = {estado_esperado, saidas_esperadas(estado_esperado)};
    fila.push_back(it);
    @(posedge clock);
    #1;
    check_output();
  endtask

  initial begin
    reset = 1'b1; iniciar = 1'b0; jogada_feita = 1'b0; igual = 1'b0;
    fim_sequencia = 1'b0; ultima_sequencia = 1'b0; fim_timer = 1'b0;
    apply_stimulus("reset", 4'h0);
    reset = 1'b0;
    apply_stimulus("idle", 4'h0);

    iniciar = 1'b1;
    apply_stimulus("preparacao", 4'h1);
    iniciar = 1'b0;
    apply_stimulus("inicio_rodada", 4'h2);
    apply_stimulus("espera", 4'h3);

    // Round 0: single correct move closes the round
    jogada_feita = 1'b1; igual = 1'b1; fim_sequencia = 1'b1;
    apply_stimulus("r0_registra", 4'h4);
    jogada_feita = 1'b0;
    apply_stimulus("r0_comparacao", 4'h5);
    apply_stimulus("r0_proxima_rodada", 4'h7);
    apply_stimulus("r0_inicio_rodada", 4'h2);
    apply_stimulus("r0_espera", 4'h3);

    // Round 1: first move advances the address, second closes the round
    fim_sequencia = 1'b0; jogada_feita = 1'b1;
    apply_stimulus("r1m0_registra", 4'h4);
    jogada_feita = 1'b0;
    apply_stimulus("r1m0_comparacao", 4'h5);
    apply_stimulus("r1m0_proximo", 4'h6);
    apply_stimulus("r1m0_espera", 4'h3);
    apply_stimulus("espera_sem_jogada", 4'h3);
    fim_sequencia = 1'b1; jogada_feita = 1'b1;
    apply_stimulus("r1m1_registra", 4'h4);
    jogada_feita = 1'b0;
    apply_stimulus("r1m1_comparacao", 4'h5);
    apply_stimulus("r1m1_proxima_rodada", 4'h7);

    // Press outside espera_jogada is dropped
    jogada_feita = 1'b1;
    apply_stimulus("jogada_ignorada_ini", 4'h2);
    apply_stimulus("jogada_ignorada_esp", 4'h3);
    jogada_feita = 1'b0;
    apply_stimulus("sem_fila_jogada", 4'h3);

    // Timer behaviour, plus move winning over a simultaneous timeout
    fim_timer = 1'b1; jogada_feita = 1'b1; fim_sequencia = 1'b0;
    apply_stimulus("jogada_vence_timer", 4'h4);
    fim_timer = 1'b0; jogada_feita = 1'b0;
    apply_stimulus("jvt_comparacao", 4'h5);
    apply_stimulus("jvt_proximo", 4'h6);
    apply_stimulus("jvt_espera", 4'h3);
`ifdef UC_TIMEOUT_EN
    fim_timer = 1'b1;
    apply_stimulus("fim_timeout", 4'hD);
    fim_timer = 1'b0;
    apply_stimulus("timeout_hold", 4'hD);
    iniciar = 1'b1;
    apply_stimulus("timeout_reinicia", 4'h1);
    iniciar = 1'b0;
    apply_stimulus("tr_inicio_rodada", 4'h2);
    apply_stimulus("tr_espera", 4'h3);
`else
    fim_timer = 1'b1;
    for (int i = 0; i < 100; i++) apply_stimulus("timer_ignorado", 4'h3);
    fim_timer = 1'b0;
`endif

    // Wrong move
    jogada_feita = 1'b1;
    apply_stimulus("err_registra", 4'h4);
    jogada_feita = 1'b0; igual = 1'b0;
    apply_stimulus("err_comparacao", 4'h5);
    apply_stimulus("fim_errou", 4'hE);
    igual = 1'b1;
    apply_stimulus("errou_hold", 4'hE);
    iniciar = 1'b1;
    apply_stimulus("errou_reinicia", 4'h1);
    iniciar = 1'b0;
    apply_stimulus("er_inicio_rodada", 4'h2);
    apply_stimulus("er_espera", 4'h3);

    // Last move of the last round wins the game
    fim_sequencia = 1'b1; ultima_sequencia = 1'b1; jogada_feita = 1'b1;
    apply_stimulus("win_registra", 4'h4);
    jogada_feita = 1'b0;
    apply_stimulus("win_comparacao", 4'h5);
    apply_stimulus("fim_acertou", 4'hA);
    apply_stimulus("acertou_hold", 4'hA);

    // Reset beats iniciar; iniciar held through reset acts on the next edge
    reset = 1'b1; iniciar = 1'b1;
    apply_stimulus("reset_prioridade", 4'h0);
    reset = 1'b0;
    apply_stimulus("iniciar_pos_reset", 4'h1);
    iniciar = 1'b0;
    apply_stimulus("pr_inicio_rodada", 4'h2);
    apply_stimulus("pr_espera", 4'h3);
    reset = 1'b1;
    apply_stimulus("reset_meio_rodada", 4'h0);
    reset = 1'b0;
    apply_stimulus("reset_idle", 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vetores, divergencias);
    $finish;
  end

endmodule

// File: doc/unidade_controle_sequencia.md
# unidade_controle_sequencia

Moore controller that sequences the memory-game datapath: clears and advances the address, limit and timeout counters, latches each player move into the move register, and checks it against the stored sequence. Each round replays one more stored entry until all 16 entries are matched, a move is wrong, or the player times out. It sits beside the datapath in the game top level. Every datapath control strobe comes from this block, and it reports the game outcome to the top level.

## Interface
- Parameters: none. Datapath widths are fixed at 4 bits (16-entry sequence).
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; forces `inicial` on the next rising edge.
- iniciar  in  1  start/restart request, level-sampled.
- jogada_feita  in  1  one-cycle pulse from the datapath edge detector when a key is pressed.
- igual  in  1  registered move equals the ROM word at the current address.
- fim_sequencia  in  1  address counter equals limit counter.
- ultima_sequencia  in  1  limit counter is at 15 (rco).
- fim_timer  in  1  timeout counter terminal count.
- zeraE, contaE  out  1  address counter clear / count enable.
- zeraL, contaL  out  1  limit counter clear / count enable.
- zeraR, registraR  out  1  move register clear / load.
- zera_timer, conta_timer  out  1  timeout counter clear / count enable.
- pronto  out  1  game finished, any outcome.
- acertou, errou, timeout  out  1  outcome flags; exactly one is high while pronto is high.
- db_estado  out  4  current state code, for the 7-segment debug display.

## Operation
Outputs are decoded from the state register only (Moore). Outputs not listed for a state are 0.
- `inicial` (0x0): no outputs. Goes to `preparacao` if iniciar, else stays.
- `preparacao` (0x1): zeraE, zeraL, zeraR, zera_timer. Goes to `inicio_rodada`.
- `inicio_rodada` (0x2): zeraE, zera_timer. Goes to `espera_jogada`.
- `espera_jogada` (0x3): conta_timer.
  - jogada_feita → `registra`.
  - else fim_timer → `fim_timeout`.
  - else stays.
- `registra` (0x4): registraR, zera_timer. Goes to `comparacao`.
- `comparacao` (0x5):
  - !igual → `fim_errou`.
  - igual & fim_sequencia & ultima_sequencia → `fim_acertou`.
  - igual & fim_sequencia → `proxima_rodada`.
  - igual → `proximo`.
- `proximo` (0x6): contaE. Goes to `espera_jogada`.
- `proxima_rodada` (0x7): contaL. Goes to `inicio_rodada`.
- `fim_acertou` (0xA): pronto, acertou.
- `fim_errou` (0xE): pronto, errou.
- `fim_timeout` (0xD): pronto, timeout.
- From any of the three final states: iniciar → `preparacao`, else hold.
- Unused codes (0x8, 0x9, 0xB, 0xC, 0xF) → `inicial` on the next edge.

## Timing
- Reset: state = `inicial`, db_estado = 0x0, every output 0, one edge after reset is sampled high. Reset mid-round abandons the round; counters are not cleared until `preparacao`.
- Reset has priority over every other input. iniciar held high through reset is honoured on the first post-reset edge.
- Simultaneous jogada_feita and fim_timer in `espera_jogada`: the move wins, no timeout.
- jogada_feita arriving outside `espera_jogada` is ignored; it is not queued.
- Latency:
  - press pulse to `registra`: 1 cycle;
  - `registra` to `comparacao`: 1 cycle. Register loaded at end of `registra`; synchronous ROM word already valid, so igual is valid throughout `comparacao`.
  - press to outcome state: 3 cycles.
- Every strobe (contaE, contaL, registraR, zera*) lasts exactly 1 cycle per visit. Counters advance by exactly 1 per visit.
- Round n (limit = n, n = 0..15) takes n+1 moves. A full game takes 136 moves.

## Configuration
- `UC_TIMEOUT_EN` defined:
  - conta_timer follows the state table above;
  - fim_timer in `espera_jogada` leads to `fim_timeout`.
- Not defined:
  - conta_timer tied to 0 and fim_timer ignored;
  - `fim_timeout` unreachable; it still decodes if entered;
  - the player waits indefinitely;
  - zera_timer behaviour unchanged.

## Test plan
- Reset with iniciar=0 → db_estado=0x0, all outputs 0. Pulse iniciar → 0x1, then 0x2, then 0x3 on consecutive edges, with zeraL=1 only in 0x1.
- Round 0, correct move: jogada_feita pulse with igual=1, fim_sequencia=1, ultima_sequencia=0 → states 0x4, 0x5, 0x7, 0x2, 0x3, with contaL high exactly 1 cycle.
- Round 2, second move correct: fim_sequencia=0 → 0x4, 0x5, 0x6 (contaE 1 cycle), then back to 0x3.
- Wrong move: igual=0 in 0x5 → 0xE, pronto=errou=1, acertou=timeout=0. Stays until iniciar=1, then 0x1.
- Final move with fim_sequencia=ultima_sequencia=igual=1 → 0xA, acertou=1.
- With UC_TIMEOUT_EN: fim_timer=1 alone in 0x3 → 0xD, timeout=1. fim_timer and jogada_feita together → 0x4. Without the macro: fim_timer=1 for 100 cycles → stays 0x3, conta_timer=0.
